// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the 2:1 round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   SEL_REQ0/1  : mux select values for requester 0 / requester 1
//   other_req() : the requester that is not the given one
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam logic SEL_REQ0 = 1'b0;
    localparam logic SEL_REQ1 = 1'b1;

    function automatic logic other_req(input logic req);
        return (req == SEL_REQ0) ? SEL_REQ1 : SEL_REQ0;
    endfunction

endpackage

// File: rtl/mux2to1_vec.sv
// mux2to1_vec: plain combinational 2:1 vector multiplexer.
//   in0_i / in1_i : candidate vectors (WIDTH bits)
//   sel_i         : 0 selects in0_i, 1 selects in1_i
//   out_o         : selected vector
module mux2to1_vec #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = in0_i;
        if (sel_i) begin
            out_o = in1_i;
        end
    end

endmodule

// File: rtl/mux2to1_rr_arbiter.sv
// mux2to1_rr_arbiter: packet-granular round-robin arbiter sharing one
// downstream valid/ready channel between two requesters.
//   clk, rst               : clock, synchronous active-high reset
//   valid0/1, data0/1,
//   last0/1                : upstream beats from requester 0/1
//   ready0/1               : beat accepted from requester 0/1
//   out_valid, out_data,
//   out_last, out_ready    : downstream channel (data/last muxed by sel)
//   sel                    : current mux select (holds through IDLE)
//   busy                   : a grant is held
// Compile option MUX_ARB_BURST_LIMIT_EN: when defined, a grant is also
// released after MAX_BURST accepted beats even without last.
module mux2to1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid0,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic                  last0,
    input  logic                  valid1,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic                  last1,
    output logic                  ready0,
    output logic                  ready1,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  sel,
    output logic                  busy
);

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       beat_acc;
    logic       beat_last;
    logic       burst_hit;

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

    logic [DATA_WIDTH:0] mux_out;

    mux2to1_vec #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_mux (
        .in0_i (({last0, data0})),
        .in1_i (({last1, data1})),
        .sel_i (sel_q),
        .out_o (mux_out)
    );

    assign {out_last, out_data} = mux_out;
    assign sel  = sel_q;
    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        out_valid = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        beat_last = 1'b0;
        burst_hit = 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
        burst_cnt_d = burst_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (valid0 && valid1) begin
                    sel_d   = rr_ptr_q;
                    state_d = (rr_ptr_q == SEL_REQ1) ? ST_GRANT1 : ST_GRANT0;
                end else if (valid0) begin
                    sel_d   = SEL_REQ0;
                    state_d = ST_GRANT0;
                end else if (valid1) begin
                    sel_d   = SEL_REQ1;
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                out_valid = valid0;
                ready0    = out_ready;
                beat_last = last0;
            end
            ST_GRANT1: begin
                out_valid = valid1;
                ready1    = out_ready;
                beat_last = last1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is evaluated before the reset mask below: reset wins in
        // the register stage anyway, so this only feeds next-state logic.
        beat_acc = out_valid & out_ready;

        if (beat_acc) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
            burst_hit   = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
            burst_cnt_d = burst_cnt_q + 1'b1;
`endif
            if (beat_last || burst_hit) begin
                state_d  = ST_IDLE;
                rr_ptr_d = other_req(sel_q);
`ifdef MUX_ARB_BURST_LIMIT_EN
                burst_cnt_d = '0;
`endif
            end
        end

        if (rst) begin
            out_valid = 1'b0;
            ready0    = 1'b0;
            ready1    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_REQ0;
            rr_ptr_q <= SEL_REQ0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    // A zero burst limit would never let a grant make progress.
    always_ff @(posedge clk) begin
        assert (MAX_BURST >= 1);
    end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
module tb_mux2to1_rr_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;
`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid0 = 1'b0, valid1 = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          last0 = 1'b0, last1 = 1'b0;
    logic          ready0, ready1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          sel;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mux2to1_rr_arbiter #(
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid0    (valid0),
        .data0     (data0),
        .last0     (last0),
        .valid1    (valid1),
        .data1     (data1),
        .last1     (last1),
        .ready0    (ready0),
        .ready1    (ready1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one further unit later, well clear of the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b0;
        last0 = 1'b0; last1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid0 = 1'b1; valid1 = 1'b1; out_ready = 1'b1;
        data0 = 8'h11; data1 = 8'h22; last0 = 1'b1; last1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if ({out_valid, ready0, ready1, busy, sel} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got v=%b r0=%b r1=%b busy=%b sel=%b expected all 0",
                         i, out_valid, ready0, ready1, busy, sel);
            end
            checks++;
            if (out_data !== 8'h11) begin
                errors++;
                $display("FAIL reset_data: got %h expected 11", out_data);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b v=%b expected 0 0", busy, out_valid);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || sel !== 1'b0 || out_valid !== 1'b1 || ready0 !== 1'b1 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got busy=%b sel=%b v=%b r0=%b r1=%b expected 1 0 1 1 0",
                     busy, sel, out_valid, ready0, ready1);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] beats [3];
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        do_reset();
        out_ready = 1'b1;
        valid1 = 1'b1; data1 = beats[0]; last1 = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b v=%b expected 0 0", busy, out_valid);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            data1 = beats[b]; last1 = (b == 2);
            #1;
            checks++;
            if (sel !== 1'b1 || out_valid !== 1'b1 || out_data !== beats[b] || out_last !== (b == 2)
                || ready1 !== 1'b1 || ready0 !== 1'b0) begin
                errors++;
                $display("FAIL single_beat%0d: got sel=%b v=%b d=%h l=%b r0=%b r1=%b expected sel=1 v=1 d=%h l=%0d r0=0 r1=1",
                         b, sel, out_valid, out_data, out_last, ready0, ready1, beats[b], (b == 2));
            end
        end
        tick();
        valid1 = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got busy=%b v=%b sel=%b expected 0 0 1", busy, out_valid, sel);
        end
    endtask

    task automatic test_contention();
        int b [2];
        int phase, pkt, r, beat;
        logic exp_sel;
        b[0] = 0; b[1] = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            valid0 = 1'b1; data0 = 8'(b[0]);      last0 = (b[0] % 2) == 1;
            valid1 = 1'b1; data1 = 8'(16 + b[1]); last1 = (b[1] % 2) == 1;
            #1;
            phase = k % 3;
            pkt   = k / 3;
            checks++;
            if (phase == 0) begin
                exp_sel = (k == 0) ? 1'b0 : 1'(((pkt - 1) % 2));
                if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== exp_sel) begin
                    errors++;
                    $display("FAIL contention_bubble k%0d: got busy=%b v=%b sel=%b expected 0 0 %b",
                             k, busy, out_valid, sel, exp_sel);
                end
            end else begin
                r    = pkt % 2;
                beat = (pkt / 2) * 2 + phase - 1;
                if (busy !== 1'b1 || sel !== 1'(r) || out_valid !== 1'b1 || out_data !== 8'(16 * r + beat)) begin
                    errors++;
                    $display("FAIL contention_grant k%0d: got busy=%b sel=%b v=%b d=%h expected 1 %0d 1 %h",
                             k, busy, sel, out_valid, out_data, r, 8'(16 * r + beat));
                end
            end
            if (ready0 === 1'b1) b[0]++;
            if (ready1 === 1'b1) b[1]++;
            tick();
        end
        valid0 = 1'b0; valid1 = 1'b0;
    endtask

    task automatic test_backpressure();
        bit g, done;
        int idx, donec;
        logic rdy;
        g = 0; done = 0; idx = 0; donec = 0;
        do_reset();
        valid1 = 1'b1; data1 = 8'h7F; last1 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rdy = !(c >= 2 && c <= 5);
            valid0 = !done; data0 = 8'(8'h20 + idx); last0 = (idx == 2);
            out_ready = rdy;
            #1;
            checks++;
            if (!done && g) begin
                if (busy !== 1'b1 || sel !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'(8'h20 + idx)
                    || ready0 !== rdy || ready1 !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_c%0d: got busy=%b sel=%b v=%b d=%h r0=%b r1=%b expected 1 0 1 %h %b 0",
                             c, busy, sel, out_valid, out_data, ready0, ready1, 8'(8'h20 + idx), rdy);
                end
            end else if (!done) begin
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_idle c%0d: got busy=%b v=%b expected 0 0", c, busy, out_valid);
                end
            end else if (c - donec == 1) begin
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_bubble: got busy=%b expected 0", busy);
                end
            end else begin
                if (busy !== 1'b1 || sel !== 1'b1 || out_data !== 8'h7F) begin
                    errors++;
                    $display("FAIL backpressure_next: got busy=%b sel=%b d=%h expected 1 1 7f", busy, sel, out_data);
                end
            end
            if (!done) begin
                if (!g) begin
                    g = 1;
                end else if (rdy) begin
                    if (idx == 2) begin
                        done = 1; donec = c;
                    end else begin
                        idx++;
                    end
                end
            end
            tick();
        end
        valid0 = 1'b0; valid1 = 1'b0;
    endtask

    task automatic test_burst_limit();
        logic [DW-1:0] exp_d [7];
        logic          exp_s [7];
        int i0, i1, n;
        if (LIMIT) begin
            exp_d[0] = 8'h30; exp_d[1] = 8'h31; exp_d[2] = 8'h32; exp_d[3] = 8'h33;
            exp_d[4] = 8'h50; exp_d[5] = 8'h34; exp_d[6] = 8'h35;
            exp_s[0] = 0; exp_s[1] = 0; exp_s[2] = 0; exp_s[3] = 0;
            exp_s[4] = 1; exp_s[5] = 0; exp_s[6] = 0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_d[k] = 8'(8'h30 + k);
                exp_s[k] = 0;
            end
            exp_d[6] = 8'h50; exp_s[6] = 1;
        end
        i0 = 0; i1 = 0; n = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            valid0 = (i0 < 6); data0 = 8'(8'h30 + i0); last0 = (i0 == 5);
            valid1 = (i1 < 1); data1 = 8'h50;          last1 = 1'b1;
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (n >= 7) begin
                    errors++;
                    $display("FAIL burst_extra_beat: got d=%h expected no beat", out_data);
                end else if (out_data !== exp_d[n] || sel !== exp_s[n]) begin
                    errors++;
                    $display("FAIL burst_beat%0d: got d=%h sel=%b expected d=%h sel=%b",
                             n, out_data, sel, exp_d[n], exp_s[n]);
                end
                n++;
            end
            if (ready0 === 1'b1 && valid0) i0++;
            if (ready1 === 1'b1 && valid1) i1++;
            tick();
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL burst_beat_count: got %0d expected 7", n);
        end
        valid0 = 1'b0; valid1 = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = 1'b1;
        // One single-beat packet from requester 0 moves the pointer to 1.
        valid0 = 1'b1; data0 = 8'h5A; last0 = 1'b1;
        tick();
        tick();
        valid0 = 1'b1; data0 = 8'h60; last0 = 1'b0;
        tick();
        data0 = 8'h60;
        tick();
        data0 = 8'h61;
        tick();
        data0 = 8'h62; rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ready0 !== 1'b0 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_forced_low: got v=%b r0=%b r1=%b expected 0 0 0", out_valid, ready0, ready1);
        end
        tick();
        rst = 1'b0; valid1 = 1'b1; data1 = 8'h99; last1 = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b v=%b sel=%b expected 0 0 0", busy, out_valid, sel);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || sel !== 1'b0 || out_data !== 8'h62) begin
            errors++;
            $display("FAIL rstmid_regrant: got busy=%b sel=%b d=%h expected 1 0 62", busy, sel, out_data);
        end
        valid0 = 1'b0; valid1 = 1'b0;
    endtask

    // Reference: owner = requester holding the packet grant (-1 none),
    // ptr = preferred requester on a tie, bc = beats taken in this grant.
    task automatic test_random();
        logic [DW-1:0] pd [2];
        logic          pl [2];
        logic          pv [2];
        bit            held [2];
        bit            need [2];
        int            rem [2];
        int            own, ptr, bc;
        logic          esel, rrdy, rrst, ev, er0, er1, ebusy, acc;
        logic [DW:0]   edat;
        own = -1; ptr = 0; bc = 0; esel = 0;
        for (int r = 0; r < 2; r++) begin
            held[r] = 0; need[r] = 1; rem[r] = 0; pv[r] = 0; pd[r] = '0; pl[r] = 0;
        end
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (need[r]) begin
                    if (rem[r] == 0) rem[r] = $urandom_range(1, 6);
                    pd[r] = 8'($urandom);
                    pl[r] = (rem[r] == 1);
                    need[r] = 0;
                end
                if (!held[r]) pv[r] = ($urandom % 4) != 0;
            end
            rrdy = ($urandom % 4) != 0;
            rrst = ($urandom % 64) == 0;
            valid0 = pv[0]; data0 = pd[0]; last0 = pl[0];
            valid1 = pv[1]; data1 = pd[1]; last1 = pl[1];
            out_ready = rrdy; rst = rrst;
            #1;
            ev = 0; er0 = 0; er1 = 0;
            if (!rrst && own >= 0) begin
                ev = pv[own];
                if (own == 0) er0 = rrdy; else er1 = rrdy;
            end
            ebusy = (own >= 0);
            edat  = esel ? {pl[1], pd[1]} : {pl[0], pd[0]};
            checks++;
            if ({out_valid, ready0, ready1, busy, sel} !== {ev, er0, er1, ebusy, esel}) begin
                errors++;
                $display("FAIL random_ctrl cyc%0d: got v,r0,r1,busy,sel=%b%b%b%b%b expected %b%b%b%b%b",
                         cyc, out_valid, ready0, ready1, busy, sel, ev, er0, er1, ebusy, esel);
            end
            checks++;
            if ({out_last, out_data} !== edat) begin
                errors++;
                $display("FAIL random_data cyc%0d: got %h expected %h", cyc, {out_last, out_data}, edat);
            end
            acc = !rrst && own >= 0 && pv[own] && rrdy;
            for (int r = 0; r < 2; r++) begin
                need[r] = acc && (own == r);
                held[r] = pv[r] && !need[r];
            end
            if (rrst) begin
                own = -1; ptr = 0; esel = 0; bc = 0;
            end else if (own < 0) begin
                if (pv[0] && pv[1]) own = ptr;
                else if (pv[0])     own = 0;
                else if (pv[1])     own = 1;
                if (own >= 0) esel = 1'(own);
            end else if (acc) begin
                rem[own]--;
                bc++;
                if (pl[own] || (LIMIT && bc == MB)) begin
                    ptr = 1 - own; own = -1; bc = 0;
                end
            end
            tick();
        end
        rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_burst_limit();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
